// File: rtl/regfile_pkg.sv
// Shared defaults for the register file scoreboard and its per-register pending counters.
package regfile_pkg;
    localparam int N_DEF     = 32;
    localparam int AW_DEF    = 5;
    localparam int CW_DEF    = 2;
    localparam int DEPTH_DEF = 2 ** AW_DEF;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction
endpackage

// File: rtl/pend_counter.sv
// Up/down saturating count of writebacks still outstanding for one architectural register.
module pend_counter #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count
);
    logic [CW-1:0] count_q, count_d;

    // Matching inc and dec cancel; the ends of the range hold rather than wrap.
    always_comb begin
        count_d = count_q;
        if (inc && !dec && count_q != '1)
            count_d = count_q + CW'(1);
        else if (dec && !inc && count_q != '0)
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with combinational reads and a pending-write scoreboard that stalls issue on hazards.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int AW     = AW_DEF,
    parameter int CW     = CW_DEF,
    parameter bit BYPASS = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [N-1:0]         wr_data,
    input  logic [AW-1:0]        rd_addr1,
    input  logic [AW-1:0]        rd_addr2,
    output logic [N-1:0]         rd_data1,
    output logic [N-1:0]         rd_data2,
    input  logic                 iss_en,
    input  logic                 iss_rd_en,
    input  logic [AW-1:0]        iss_rd,
    input  logic [AW-1:0]        iss_rs1,
    input  logic [AW-1:0]        iss_rs2,
    output logic                 stall,
    output logic [2**AW-1:0]     busy
);
    localparam int DEPTH = depth_of(AW);

    logic [N-1:0]                mem_q [DEPTH];
    logic [N-1:0]                mem_d [DEPTH];
    logic [DEPTH-1:0][CW-1:0]    pend;
    logic                        wr_live;
    logic                        accept;

    assign wr_live = wr_en && (wr_addr != '0);

    always_comb begin
        mem_d = mem_q;
        if (wr_live) mem_d[wr_addr] = wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        rd_data1 = mem_q[rd_addr1];
        rd_data2 = mem_q[rd_addr2];
        if (BYPASS && wr_live && wr_addr == rd_addr1) rd_data1 = wr_data;
        if (BYPASS && wr_live && wr_addr == rd_addr2) rd_data2 = wr_data;
    end

    // A single outstanding write being retired this cycle is not a hazard when forwarding is on.
    function automatic logic hazard(input logic [AW-1:0] r);
        logic released;
        released = BYPASS && pend[r] == CW'(1) && wr_en && wr_addr == r;
        return (pend[r] != '0) && !released;
    endfunction

    always_comb begin
        stall  = iss_en && (hazard(iss_rs1) || hazard(iss_rs2) ||
                            (iss_rd_en && pend[iss_rd] == '1));
        accept = iss_en && !stall;
    end

    assign pend[0] = '0;

    for (genvar i = 1; i < DEPTH; i++) begin : g_pend
        pend_counter #(.CW(CW)) u_pend (
            .clk   (clk),
            .reset (reset),
            .inc   (accept && iss_rd_en && iss_rd == AW'(i)),
            .dec   (wr_en && wr_addr == AW'(i)),
            .count (pend[i])
        );
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) busy[i] = (pend[i] != '0);
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Drives a forwarding and a non-forwarding scoreboard with shared stimulus against an array/count model.
module tb_regfile_scoreboard;
    localparam int N = 32, AW = 5, CW = 2, DEPTH = 32, PMAX = 3;

    logic          clk = 1'b0;
    logic          reset, wr_en, iss_en, iss_rd_en;
    logic [AW-1:0] wr_addr, rd_addr1, rd_addr2, iss_rd, iss_rs1, iss_rs2;
    logic [N-1:0]  wr_data;
    logic [N-1:0]  rd1 [2], rd2 [2];
    logic          stl [2];
    logic [DEPTH-1:0] bsy [2];

    int checks = 0, failures = 0;

    logic [N-1:0] m_mem [DEPTH];
    int           m_pend [2][DEPTH];

    always #5 clk = ~clk;

    // Index 0: no forwarding, index 1: forwarding.
    regfile_scoreboard #(.N(N), .AW(AW), .CW(CW), .BYPASS(1'b0)) u_nb (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd1[0]), .rd_data2(rd2[0]),
        .iss_en(iss_en), .iss_rd_en(iss_rd_en), .iss_rd(iss_rd), .iss_rs1(iss_rs1),
        .iss_rs2(iss_rs2), .stall(stl[0]), .busy(bsy[0]));

    regfile_scoreboard #(.N(N), .AW(AW), .CW(CW), .BYPASS(1'b1)) u_byp (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd1[1]), .rd_data2(rd2[1]),
        .iss_en(iss_en), .iss_rd_en(iss_rd_en), .iss_rd(iss_rd), .iss_rs1(iss_rs1),
        .iss_rs2(iss_rs2), .stall(stl[1]), .busy(bsy[1]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] m_read(input int v, input int a);
        if (v == 1 && wr_en && int'(wr_addr) == a && a != 0) return wr_data;
        return (a == 0) ? '0 : m_mem[a];
    endfunction

    function automatic bit m_hazard(input int v, input int r);
        if (m_pend[v][r] == 0) return 1'b0;
        return !(v == 1 && m_pend[v][r] == 1 && wr_en && int'(wr_addr) == r);
    endfunction

    function automatic bit m_stall(input int v);
        return iss_en && (m_hazard(v, int'(iss_rs1)) || m_hazard(v, int'(iss_rs2)) ||
                          (iss_rd_en && m_pend[v][int'(iss_rd)] == PMAX));
    endfunction

    function automatic logic [DEPTH-1:0] m_busy(input int v);
        logic [DEPTH-1:0] b;
        for (int r = 0; r < DEPTH; r++) b[r] = (m_pend[v][r] > 0);
        return b;
    endfunction

    task automatic m_reset();
        for (int r = 0; r < DEPTH; r++) begin
            m_mem[r] = '0;
            m_pend[0][r] = 0;
            m_pend[1][r] = 0;
        end
    endtask

    // Compare combinational outputs of both variants at the falling edge.
    task automatic eval();
        @(negedge clk);
        for (int v = 0; v < 2; v++) begin
            check($sformatf("rd1_v%0d_a%0d", v, rd_addr1), rd1[v], m_read(v, int'(rd_addr1)));
            check($sformatf("rd2_v%0d_a%0d", v, rd_addr2), rd2[v], m_read(v, int'(rd_addr2)));
            check($sformatf("stall_v%0d", v), 32'(stl[v]), 32'(m_stall(v)));
            check($sformatf("busy_v%0d", v), bsy[v], m_busy(v));
        end
    endtask

    task automatic tick();
        bit acc [2];
        @(posedge clk);
        if (reset) begin
            m_reset();
        end else begin
            for (int v = 0; v < 2; v++) acc[v] = iss_en && !m_stall(v);
            for (int v = 0; v < 2; v++) begin
                if (acc[v] && iss_rd_en && iss_rd != 0)
                    m_pend[v][int'(iss_rd)] = m_pend[v][int'(iss_rd)] + 1;
                if (wr_en && wr_addr != 0 && m_pend[v][int'(wr_addr)] > 0)
                    m_pend[v][int'(wr_addr)] = m_pend[v][int'(wr_addr)] - 1;
            end
            if (wr_en && wr_addr != 0) m_mem[int'(wr_addr)] = wr_data;
        end
        #1;
    endtask

    task automatic idle();
        reset = 0; wr_en = 0; wr_addr = 0; wr_data = 0; rd_addr1 = 0; rd_addr2 = 0;
        iss_en = 0; iss_rd_en = 0; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
    endtask

    task automatic issue(input int rd, input int rs1, input int rs2);
        iss_en = 1; iss_rd_en = (rd != 0); iss_rd = AW'(rd); iss_rs1 = AW'(rs1); iss_rs2 = AW'(rs2);
    endtask

    task automatic wb(input int a, input logic [N-1:0] d);
        wr_en = 1; wr_addr = AW'(a); wr_data = d;
    endtask

    initial begin
        idle();
        m_reset();
        reset = 1;
        tick();
        idle();

        // Reset state on every address.
        for (int a = 0; a < DEPTH; a += 2) begin
            rd_addr1 = AW'(a); rd_addr2 = AW'(a + 1);
            eval();
            check("rst_rd1", rd1[1], 32'h0);
            check("rst_busy", bsy[0], 32'h0);
            tick();
        end

        // Same-cycle write/read forwarding, then x0 write ignored.
        idle(); wb(5, 32'hDEADBEEF); rd_addr1 = 5;
        eval();
        check("fwd_byp", rd1[1], 32'hDEADBEEF);
        check("fwd_nobyp", rd1[0], 32'h0);
        tick();
        idle(); rd_addr1 = 5;
        eval();
        check("x5_after", rd1[0], 32'hDEADBEEF);
        tick();
        idle(); wb(0, 32'h1234); rd_addr2 = 0;
        eval();
        check("x0_fwd", rd2[1], 32'h0);
        tick();
        idle(); rd_addr2 = 0;
        eval();
        check("x0_read", rd2[0], 32'h0);
        tick();

        // RAW hazard on x3 and its release by writeback.
        idle(); issue(3, 0, 0); eval(); tick();
        idle(); issue(0, 3, 0);
        eval();
        check("raw_stall", 32'(stl[1]), 32'h1);
        check("raw_busy3", 32'(bsy[1][3]), 32'h1);
        tick();
        idle(); issue(0, 3, 0); wb(3, 32'h33);
        eval();
        check("rel_byp", 32'(stl[1]), 32'h0);
        check("rel_nobyp", 32'(stl[0]), 32'h1);
        tick();
        idle(); eval();
        check("busy3_clr", 32'(bsy[0][3] | bsy[1][3]), 32'h0);
        tick();

        // Counter saturation on x7 blocks a fourth issue.
        for (int k = 0; k < 3; k++) begin idle(); issue(7, 0, 0); eval(); tick(); end
        idle(); issue(7, 0, 0);
        eval();
        check("sat_stall", 32'(stl[1]), 32'h1);
        tick();
        idle(); wb(7, 32'h77); eval(); tick();
        idle(); issue(7, 0, 0);
        eval();
        check("sat_accept", 32'(stl[1]), 32'h0);
        tick();
        for (int k = 0; k < 3; k++) begin idle(); wb(7, 32'h7); eval(); tick(); end

        // Issue and retire of x4 in the same cycle leave its count at one.
        idle(); issue(4, 0, 0); eval(); tick();
        idle(); issue(4, 0, 0); wb(4, 32'h44); eval(); tick();
        idle(); eval();
        check("x4_busy", 32'(bsy[1][4]), 32'h1);
        tick();
        idle(); wb(4, 32'h45); eval(); tick();

        // Reset mid-stream drops in-flight counts; later writeback stores data only.
        idle(); issue(9, 0, 0); eval(); tick();
        idle(); issue(9, 0, 0); eval(); tick();
        idle(); reset = 1; issue(9, 0, 0); wb(9, 32'hBAD); eval(); tick();
        idle(); eval();
        check("rst_mid_busy", bsy[1], 32'h0);
        tick();
        idle(); wb(9, 32'h99); eval(); tick();
        idle(); rd_addr1 = 9;
        eval();
        check("x9_data", rd1[0], 32'h99);
        check("x9_busy", 32'(bsy[0][9]), 32'h0);
        tick();

        // Randomized traffic concentrated on a few registers to provoke hazards.
        for (int c = 0; c < 600; c++) begin
            idle();
            reset     = ($urandom_range(0, 59) == 0);
            wr_en     = $urandom_range(0, 1);
            wr_addr   = AW'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
            wr_data   = $urandom;
            rd_addr1  = AW'($urandom_range(0, 1) ? int'(wr_addr) : $urandom_range(0, 31));
            rd_addr2  = AW'($urandom_range(0, 31));
            iss_en    = $urandom_range(0, 1);
            iss_rd_en = $urandom_range(0, 1);
            iss_rd    = AW'($urandom_range(0, 7));
            iss_rs1   = AW'($urandom_range(0, 7));
            iss_rs2   = AW'($urandom_range(0, 7));
            eval();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter N, default 32, data width in bits.
REQ-002 SHALL have parameter AW, default 5, address width; depth 2**AW registers.
REQ-003 SHALL have parameter CW, default 2, pending-write counter width per register.
REQ-004 SHALL have parameter BYPASS, default 1, enabling write-to-read forwarding and writeback hazard release.
REQ-005 SHALL have clk  in  1  sole clock, all state updates on rising edge.
REQ-006 SHALL have reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have wr_en  in  1  writeback strobe.
REQ-008 SHALL have wr_addr  in  AW  writeback destination.
REQ-009 SHALL have wr_data  in  N  writeback data.
REQ-010 SHALL have rd_addr1, rd_addr2  in  AW each  read-port addresses.
REQ-011 SHALL have rd_data1, rd_data2  out  N each  read-port data.
REQ-012 SHALL have iss_en  in  1  an instruction requests issue.
REQ-013 SHALL have iss_rd_en  in  1  issuing instruction writes a destination.
REQ-014 SHALL have iss_rd  in  AW  destination of issuing instruction.
REQ-015 SHALL have iss_rs1, iss_rs2  in  AW each  sources of issuing instruction.
REQ-016 SHALL have stall  out  1  issue refused this cycle.
REQ-017 SHALL have busy  out  2**AW  bit i = pending count of register i nonzero.

Function
REQ-018 Register 0 SHALL read 0 always; writes and issues targeting it SHALL be ignored (counter stays 0).
REQ-019 Reads SHALL be combinational; with BYPASS=1 and wr_en, wr_addr==rd_addrX, wr_addr!=0, rd_dataX SHALL equal wr_data same cycle; BYPASS=0 returns stored value.
REQ-020 Write SHALL update storage at the edge when wr_en=1 and wr_addr!=0.
REQ-021 Source hazard: register r hazardous if pend[r]!=0, except when BYPASS=1, pend[r]==1, wr_en=1, wr_addr==r.
REQ-022 stall SHALL be combinational = iss_en and (hazard(iss_rs1) or hazard(iss_rs2) or (iss_rd_en and pend[iss_rd]==2**CW-1)).
REQ-023 Issue accepted when iss_en=1 and stall=0; acceptance with iss_rd_en and iss_rd!=0 SHALL increment pend[iss_rd].
REQ-024 wr_en with wr_addr!=0 SHALL decrement pend[wr_addr]; decrement at 0 SHALL be ignored (counter never wraps below 0).
REQ-025 Simultaneous accepted increment and decrement of same register SHALL leave its counter unchanged.
REQ-026 Counters SHALL never wrap above 2**CW-1; saturation prevented only via stall per REQ-022.
REQ-027 busy SHALL reflect registered counter state (no bypass); busy[0]=0 always.
REQ-028 Read ports SHALL be independent of issue/stall state.

Reset
REQ-029 reset=1 at an edge SHALL clear all data registers and all pending counters in that single cycle, overriding same-cycle write and issue.
REQ-030 After reset: rd_data1/2=0 (absent bypass), busy=0, stall=0.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight pending counts; later writebacks to zero counters follow REQ-024.

Structure
REQ-032 Package regfile_pkg SHALL hold default N, AW, CW and derived DEPTH constant.
REQ-033 Per-register up/down saturating counter SHALL be sub-module pend_counter (inc, dec, sync reset, count out), instantiated per register 1..DEPTH-1 in a generate loop.

Verification
REQ-034 reset, then read all addresses -> every rd_data=0, busy=0, stall=0.
REQ-035 write x5=0xDEADBEEF, read rd_addr1=5 same cycle -> 0xDEADBEEF (BYPASS=1), stored value (BYPASS=0); next cycle 0xDEADBEEF either way; write x0=0x1234 -> x0 reads 0.
REQ-036 issue rd=3, next cycle issue rs1=3 -> stall=1, busy[3]=1; writeback x3 same cycle -> stall=0 (BYPASS=1), stall=1 (BYPASS=0); cycle after -> busy[3]=0.
REQ-037 CW=2: three issues rd=7 without writeback -> pend=3; fourth issue rd=7 -> stall=1; one writeback -> next issue accepted.
REQ-038 pend[4]=1, accepted issue rd=4 with simultaneous writeback x4 -> pend[4] remains 1, busy[4]=1.
REQ-039 pend[9]=2 then reset mid-stream -> busy=0; subsequent writeback x9 -> pend stays 0, data stored.
